imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: receives a program as a byte stream
//  (valid/ready), assembles little-endian 32-bit words and writes them into the
//  instruction memory's write port. Holds the CPU (cpu_hold) from reset until a
//  load completes. Sits between the host byte source and the instruction memory.
// PARAMETERS
//  DEPTH      256  instruction memory depth in 32-bit words; max loadable N
//  BASE_ADDR  0    byte address of the first word written (must be 4-aligned)
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   begin a load; honoured only in IDLE
//  rx_valid     in   1   byte available on rx_data
//  rx_data      in   8   stream byte
//  rx_ready     out  1   loader accepts a byte; transfer = rx_valid & rx_ready
//  mem_we       out  1   instruction memory write enable, one-cycle pulse per word
//  mem_addr     out  32  byte address of the word being written; [1:0] always 0
//  mem_wdata    out  32  assembled instruction word
//  cpu_hold     out  1   keep the CPU/PC in reset while high
//  load_done    out  1   one-cycle pulse on successful completion
//  load_err     out  1   sticky: header N > DEPTH; cleared by the next accepted start
//  words_loaded out  9   count of words written in the current/last load
// BEHAVIOUR
//  Reset values: state=IDLE, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR,
//   mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
//  Stream format: 2-byte header N (little-endian, 16 bit), then N*4 data bytes;
//   byte k of each word -> mem_wdata[8k+7:8k], k=0..3.
//  FSM states: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
//   IDLE:   rx_ready=0; start -> HDR_LO, load_err<=0, words_loaded<=0, cpu_hold=1.
//   HDR_LO: rx_ready=1; on transfer latch N[7:0] -> HDR_HI.
//   HDR_HI: rx_ready=1; on transfer latch N[15:8]; N==0 -> DONE;
//           N>DEPTH -> ERR; else -> DATA with byte index=0.
//   DATA:   rx_ready=1; on transfer place byte, index++; after 4th byte -> WRITE.
//   WRITE:  rx_ready=0; mem_we=1 for exactly this cycle,
//           mem_addr=BASE_ADDR+{words_loaded,2'b00}; next cycle words_loaded++,
//           then ==N -> DONE, else -> DATA.
//   DONE:   load_done=1 for one cycle, cpu_hold<=0 in the same cycle -> IDLE.
//   ERR:    load_err<=1, cpu_hold stays 1, rx_ready=0 -> IDLE.
//  Latency: mem_we is asserted the cycle after the 4th byte of a word is
//   accepted. Throughput: 5 cycles/word with rx_valid held high.
//  rx_valid low: state holds, no timeout. A byte offered while rx_ready=0 is
//   not consumed and must stay stable on rx_data.
//  start outside IDLE is ignored. A start arriving in the same cycle as a DONE
//   or ERR exit is ignored; it takes effect only when sampled in IDLE.
//  Reload after success: start raises cpu_hold again and overwrites from BASE_ADDR.
//  rst mid-load: immediate abort to reset values. Words already written stay in
//   memory; no partial word is written.
//  mem_wdata holds its last value outside WRITE. Address arithmetic is modulo
//   2^32; N<=DEPTH guarantees no wrap inside the memory.
// STRUCTURE
//  Shared header (riscv_defs.vh): loader FSM state encodings, IMEM_DEPTH
//   constant (shared with the instruction memory), header byte count.
//  Sub-module: imem_byte_assembler. 2-bit byte index plus 32-bit word register;
//   inputs byte_en/byte_in/clear; outputs word and word_full.
// TESTING
//  1 assert rst -> all outputs at reset values, cpu_hold=1, no mem_we.
//  2 start; bytes 02 00 13 05 A0 00 93 05 B0 00 -> writes (0x0,0x00A00513),
//    (0x4,0x00B00593); then load_done pulse, cpu_hold=0, words_loaded=2.
//  3 start; header 00 00 -> load_done pulse with no mem_we, cpu_hold=0.
//  4 start; header 01 01 (N=257, DEPTH=256) -> load_err=1, no writes,
//    cpu_hold=1, rx_ready=0; next start clears load_err.
//  5 repeat test 2 with random rx_valid gaps and start pulses mid-load ->
//    identical writes and timing-independent result.
//  6 rst after 6 data bytes -> exactly one write seen; a fresh load then
//    succeeds from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// the instruction memory depth and the word address helper.
package imem_loader_pkg;

  // Depth of the instruction memory in 32-bit words, shared with the memory itself
  localparam int unsigned IMEM_DEPTH = 256;

  // Loader FSM state encodings
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_LO = 3'd1;
  localparam logic [2:0] ST_HDR_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // Byte address of word number idx, counted from base (wraps modulo 2^32)
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [8:0]  idx);
    return base + {21'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// Packs a stream of bytes into a little-endian 32-bit word. word_full_o flags
// that the byte presented this cycle completes the word, so the word register
// holds the complete word from the following cycle on.
module imem_byte_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_in_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // Next-state: clear restarts at byte 0, otherwise each enabled byte lands in its lane
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
    end else if (byte_en_i) begin
      case (idx_q)
        2'd0:    word_d[7:0]   = byte_in_i;
        2'd1:    word_d[15:8]  = byte_in_i;
        2'd2:    word_d[23:16] = byte_in_i;
        default: word_d[31:24] = byte_in_i;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  // Byte index and word register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = byte_en_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction memory writer: takes a length-prefixed byte stream, assembles
// little-endian words and writes them to consecutive word addresses starting
// at BASE_ADDR. Holds the CPU in reset until a load finishes successfully.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic [8:0]  words_loaded_o
);

  state_t      state_q, state_d;
  logic [7:0]  n_lo_q, n_lo_d;
  logic [15:0] n_q, n_d;
  logic [8:0]  words_q, words_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;

  logic        transfer;
  logic        asm_clear;
  logic        asm_byte_en;
  logic [31:0] asm_word;
  logic        asm_full;
  logic [15:0] hdr_n;

  assign rx_ready_o = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                      (state_q == ST_DATA);
  assign transfer   = rx_valid_i && rx_ready_o;
  assign hdr_n      = {rx_data_i, n_lo_q};

  imem_byte_assembler u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (asm_clear),
    .byte_en_i   (asm_byte_en),
    .byte_in_i   (rx_data_i),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  // Loader FSM next-state; cpu_hold drops on entry to DONE so it is low during the done pulse
  always_comb begin
    state_d     = state_q;
    n_lo_d      = n_lo_q;
    n_d         = n_q;
    words_d     = words_q;
    hold_d      = hold_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    asm_clear   = 1'b0;
    asm_byte_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_HDR_LO;
          err_d     = 1'b0;
          words_d   = 9'd0;
          hold_d    = 1'b1;
          asm_clear = 1'b1;
        end
      end
      ST_HDR_LO: begin
        if (transfer) begin
          n_lo_d  = rx_data_i;
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (transfer) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d = ST_DONE;
            hold_d  = 1'b0;
          end else if (32'(hdr_n) > DEPTH) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (transfer) begin
          asm_byte_en = 1'b1;
          if (asm_full) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        wdata_d = asm_word;
        words_d = words_q + 9'd1;
        if ({7'd0, words_q} + 16'd1 == n_q) begin
          state_d = ST_DONE;
          hold_d  = 1'b0;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      n_lo_q  <= 8'd0;
      n_q     <= 16'd0;
      words_q <= 9'd0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      n_lo_q  <= n_lo_d;
      n_q     <= n_d;
      words_q <= words_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we_o       = (state_q == ST_WRITE);
  assign mem_addr_o     = word_byte_addr(BASE_ADDR, words_q);
  assign mem_wdata_o    = (state_q == ST_WRITE) ? asm_word : wdata_q;
  assign cpu_hold_o     = hold_q;
  assign load_done_o    = (state_q == ST_DONE);
  assign load_err_o     = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: normal load, empty load, oversize
// header, gapped stream with stray starts, and reset in the middle of a load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .rx_ready_o     (rx_ready),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .cpu_hold_o     (cpu_hold),
    .load_done_o    (load_done),
    .load_err_o     (load_err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int done_cnt   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  // Free-running cycle count used to time writes
  always @(posedge clk) cycle <= cycle + 1;

  // Log every memory write and done pulse at mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cycle);
    end
    if (load_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after an optional gap (with start optionally held during the gap)
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit acc;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      start    = poke;
      tick();
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    acc      = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = rx_ready;
      tick();
    end
    rx_valid = 1'b0;
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL byte_accept: byte %02h not accepted, got rx_ready=%0b, need 1", b, rx_ready);
    end
  endtask

  // Advance until load_done is high (at most 30 cycles); leaves the bench in the DONE cycle
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (load_done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick(); tick();
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rx_ready: got %b need 0", rx_ready); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %b need 0", mem_we); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h need 0", mem_addr); end
    compared++; if (mem_wdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_wdata: got %h need 0", mem_wdata); end
    compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cpu_hold: got %b need 1", cpu_hold); end
    compared++; if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load_done: got %b need 0", load_done); end
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load_err: got %b need 0", load_err); end
    compared++; if (words_loaded !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_words: got %0d need 0", words_loaded); end
    rst = 1'b0;
    tick(); tick();
    compared++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_after_reset: got ready=%b hold=%b need 0/1", rx_ready, cpu_hold); end
    compared++; if (wr_addr.size() != 0) begin mismatched++; $display("[TB] FAIL reset_no_write: got %0d writes need 0", wr_addr.size()); end
  endtask

  task automatic test_load_two_words();
    int base;
    int dc;
    bit seen;
    base = wr_addr.size();
    dc   = done_cnt;
    pulse_start();
    compared++; if (rx_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL load_ready_hdr: got %b need 1", rx_ready); end
    send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'h13, 0, 1'b0); send_byte(8'h05, 0, 1'b0);
    send_byte(8'hA0, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    compared++; if (mem_we !== 1'b1 || rx_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL write_latency: got we=%b ready=%b need 1/0", mem_we, rx_ready); end
    compared++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h00A00513) begin mismatched++; $display("[TB] FAIL write0_live: got %h/%h need 00000000/00a00513", mem_addr, mem_wdata); end
    send_byte(8'h93, 0, 1'b0); send_byte(8'h05, 0, 1'b0);
    send_byte(8'hB0, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    wait_done(seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL load_done_seen: got no pulse need pulse"); end
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL load_hold_at_done: got %b need 0", cpu_hold); end
    compared++; if (words_loaded !== 9'd2) begin mismatched++; $display("[TB] FAIL load_words: got %0d need 2", words_loaded); end
    compared++; if (wr_addr.size() != base + 2) begin mismatched++; $display("[TB] FAIL load_write_count: got %0d need %0d", wr_addr.size() - base, 2); end
    else begin
      compared++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00A00513) begin mismatched++; $display("[TB] FAIL load_write0: got %h/%h need 00000000/00a00513", wr_addr[base], wr_data[base]); end
      compared++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00B00593) begin mismatched++; $display("[TB] FAIL load_write1: got %h/%h need 00000004/00b00593", wr_addr[base+1], wr_data[base+1]); end
      compared++; if (wr_cyc[base+1] - wr_cyc[base] != 5) begin mismatched++; $display("[TB] FAIL load_throughput: got %0d cycles need 5", wr_cyc[base+1] - wr_cyc[base]); end
    end
    tick();
    compared++; if (load_done !== 1'b0 || done_cnt != dc + 1) begin mismatched++; $display("[TB] FAIL load_done_width: got done=%b pulses=%0d need 0/1", load_done, done_cnt - dc); end
    compared++; if (cpu_hold !== 1'b0 || mem_wdata !== 32'h00B00593) begin mismatched++; $display("[TB] FAIL load_after_done: got hold=%b wdata=%h need 0/00b00593", cpu_hold, mem_wdata); end
  endtask

  task automatic test_empty_load();
    int base;
    bit seen;
    base = wr_addr.size();
    pulse_start();
    compared++; if (cpu_hold !== 1'b1 || words_loaded !== 9'd0) begin mismatched++; $display("[TB] FAIL reload_hold: got hold=%b words=%0d need 1/0", cpu_hold, words_loaded); end
    send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    wait_done(seen);
    compared++; if (!seen || cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL empty_done: got seen=%b hold=%b need 1/0", seen, cpu_hold); end
    compared++; if (wr_addr.size() != base || words_loaded !== 9'd0) begin mismatched++; $display("[TB] FAIL empty_no_write: got %0d writes words=%0d need 0/0", wr_addr.size() - base, words_loaded); end
    tick();
  endtask

  task automatic test_oversize();
    int base;
    int dc;
    bit seen;
    base = wr_addr.size();
    dc   = done_cnt;
    pulse_start();
    send_byte(8'h01, 0, 1'b0); send_byte(8'h01, 0, 1'b0);
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL err_ready: got %b need 0", rx_ready); end
    tick();
    compared++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL err_flags: got err=%b hold=%b need 1/1", load_err, cpu_hold); end
    tick(); tick();
    compared++; if (load_err !== 1'b1 || rx_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL err_sticky: got err=%b ready=%b need 1/0", load_err, rx_ready); end
    compared++; if (wr_addr.size() != base || done_cnt != dc) begin mismatched++; $display("[TB] FAIL err_no_activity: got writes=%0d done=%0d need 0/0", wr_addr.size() - base, done_cnt - dc); end
    pulse_start();
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("[TB] FAIL err_cleared: got %b need 0", load_err); end
    send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    wait_done(seen);
    tick();
  endtask

  task automatic test_gaps_and_stray_start();
    logic [7:0] bytes [10];
    int gaps [10];
    int base;
    bit seen;
    bytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    gaps  = '{1, 0, 3, 2, 0, 1, 2, 0, 4, 1};
    base = wr_addr.size();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(bytes[i], gaps[i], (i % 2) == 0);
    wait_done(seen);
    compared++; if (!seen || words_loaded !== 9'd2 || cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL gap_done: got seen=%b words=%0d hold=%b need 1/2/0", seen, words_loaded, cpu_hold); end
    compared++; if (wr_addr.size() != base + 2) begin mismatched++; $display("[TB] FAIL gap_write_count: got %0d need 2", wr_addr.size() - base); end
    else begin
      compared++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00A00513 || wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00B00593) begin mismatched++; $display("[TB] FAIL gap_writes: got %h/%h %h/%h need 0/00a00513 4/00b00593", wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]); end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL start_on_done: got ready=%b need 0", rx_ready); end
    tick();
    compared++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_after_done: got ready=%b hold=%b need 0/0", rx_ready, cpu_hold); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    bit seen;
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'h13, 0, 1'b0); send_byte(8'h05, 0, 1'b0);
    send_byte(8'hA0, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'h93, 0, 1'b0); send_byte(8'h05, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    compared++; if (rx_ready !== 1'b0 || mem_we !== 1'b0 || cpu_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_ctrl: got ready=%b we=%b hold=%b need 0/0/1", rx_ready, mem_we, cpu_hold); end
    compared++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || words_loaded !== 9'd0) begin mismatched++; $display("[TB] FAIL abort_data: got %h/%h/%0d need 0/0/0", mem_addr, mem_wdata, words_loaded); end
    compared++; if (wr_addr.size() != base + 1) begin mismatched++; $display("[TB] FAIL abort_write_count: got %0d need 1", wr_addr.size() - base); end
    tick();
    rst = 1'b0;
    tick();
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h01, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'h78, 0, 1'b0); send_byte(8'h56, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0); send_byte(8'h12, 0, 1'b0);
    wait_done(seen);
    compared++; if (!seen || words_loaded !== 9'd1) begin mismatched++; $display("[TB] FAIL fresh_done: got seen=%b words=%0d need 1/1", seen, words_loaded); end
    compared++; if (wr_addr.size() != base + 1) begin mismatched++; $display("[TB] FAIL fresh_write_count: got %0d need 1", wr_addr.size() - base); end
    else begin
      compared++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h12345678) begin mismatched++; $display("[TB] FAIL fresh_write: got %h/%h need 00000000/12345678", wr_addr[base], wr_data[base]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_two_words();
    test_empty_load();
    test_oversize();
    test_gaps_and_stray_start();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
